// File: rtl/psram_pkg.sv
// Shared types and CA-word layout for the PSRAM PHY sequencer.
package psram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA0,
    S_CA1,
    S_CA2,
    S_LAT,
    S_DATA,
    S_RECOV
  } state_t;

  localparam int CA_W         = 48;
  localparam int CA_RW_BIT    = 47;
  localparam int CA_AS_BIT    = 46;
  localparam int CA_BURST_BIT = 45;
  localparam int CA_ROW_HI    = 34;
  localparam int CA_ROW_LO    = 16;
  localparam int CA_COL_HI    = 2;
  localparam int CA_COL_LO    = 0;

  // Read is CA[47]=1; address space is always memory; burst is linear.
  function automatic logic [CA_W-1:0] build_ca(input logic we, input logic [21:0] addr);
    logic [CA_W-1:0] ca;
    ca                        = '0;
    ca[CA_RW_BIT]             = ~we;
    ca[CA_AS_BIT]             = 1'b0;
    ca[CA_BURST_BIT]          = 1'b1;
    ca[CA_ROW_HI:CA_ROW_LO]   = addr[21:3];
    ca[CA_COL_HI:CA_COL_LO]   = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/psram_phy_sequencer.sv
// Per-access CA/data/recovery sequencer feeding the PSRAM ODDR/IOBUF pin stage.
// Optional byte masking on writes via RWDS: define PSRAM_WRITE_MASK_EN.
module psram_phy_sequencer
  import psram_pkg::*;
#(
  parameter int LATENCY   = 6,
  parameter int RECOVERY  = 2,
  parameter int RD_WINDOW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [21:0] addr,
  input  logic [15:0] wdata,
  input  logic [1:0]  wmask,
  output logic        ack,
  output logic        busy,
  output logic        cs_n,
  output logic        ck_en,
  output logic [7:0]  dq_d0,
  output logic [7:0]  dq_d1,
  output logic        dq_oen,
  output logic        rwds_d0,
  output logic        rwds_d1,
  output logic        rwds_oen,
  output logic        rd_window
);

  localparam logic [3:0] LAT_LD = 4'(LATENCY - 1);
  localparam logic [3:0] RDW_LD = 4'(RD_WINDOW - 1);
  localparam logic [3:0] REC_LD = 4'(RECOVERY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic [CA_W-1:0]   ca_q, ca_sel;

  logic              busy_d, cs_n_d, ck_en_d, dq_oen_d, rwds_oen_d, rd_window_d;
  logic              rwds_d0_d, rwds_d1_d;
  logic [7:0]        dq_d0_d, dq_d1_d;

`ifdef PSRAM_WRITE_MASK_EN
  logic [1:0]        wmask_q;
`else
  logic              unused_wmask;
  assign unused_wmask = ^wmask;
`endif

  assign accept = (state_q == S_IDLE) && req;
  // The CA0 bytes are emitted on the acceptance edge, before the latch holds them.
  assign ca_sel = accept ? build_ca(we, addr) : ca_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_CA0;
      S_CA0:   state_d = S_CA1;
      S_CA1:   state_d = S_CA2;
      S_CA2: begin
        state_d = S_LAT;
        cnt_d   = LAT_LD;
      end
      S_LAT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          cnt_d   = we_q ? 4'd0 : RDW_LD;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_DATA: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECOV;
          cnt_d   = REC_LD;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_RECOV: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values are decoded from the state being entered so they register in step with it.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    cs_n_d      = 1'b1;
    ck_en_d     = 1'b0;
    dq_d0_d     = 8'h00;
    dq_d1_d     = 8'h00;
    dq_oen_d    = 1'b1;
    rwds_d0_d   = 1'b0;
    rwds_d1_d   = 1'b0;
    rwds_oen_d  = 1'b1;
    rd_window_d = 1'b0;
    if (state_d inside {S_CA0, S_CA1, S_CA2, S_LAT, S_DATA}) begin
      cs_n_d  = 1'b0;
      ck_en_d = 1'b1;
    end
    case (state_d)
      S_CA0: begin
        dq_d0_d  = ca_sel[47:40];
        dq_d1_d  = ca_sel[39:32];
        dq_oen_d = 1'b0;
      end
      S_CA1: begin
        dq_d0_d  = ca_sel[31:24];
        dq_d1_d  = ca_sel[23:16];
        dq_oen_d = 1'b0;
      end
      S_CA2: begin
        dq_d0_d  = ca_sel[15:8];
        dq_d1_d  = ca_sel[7:0];
        dq_oen_d = 1'b0;
      end
      S_DATA: begin
        if (we_q) begin
          dq_d0_d    = wdata_q[15:8];
          dq_d1_d    = wdata_q[7:0];
          dq_oen_d   = 1'b0;
          rwds_oen_d = 1'b0;
`ifdef PSRAM_WRITE_MASK_EN
          rwds_d0_d  = ~wmask_q[1];
          rwds_d1_d  = ~wmask_q[0];
`endif
        end else begin
          rd_window_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      ck_en     <= 1'b0;
      dq_d0     <= 8'h00;
      dq_d1     <= 8'h00;
      dq_oen    <= 1'b1;
      rwds_d0   <= 1'b0;
      rwds_d1   <= 1'b0;
      rwds_oen  <= 1'b1;
      rd_window <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack       <= accept;
      busy      <= busy_d;
      cs_n      <= cs_n_d;
      ck_en     <= ck_en_d;
      dq_d0     <= dq_d0_d;
      dq_d1     <= dq_d1_d;
      dq_oen    <= dq_oen_d;
      rwds_d0   <= rwds_d0_d;
      rwds_d1   <= rwds_d1_d;
      rwds_oen  <= rwds_oen_d;
      rd_window <= rd_window_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      wdata_q <= wdata;
      ca_q    <= ca_sel;
`ifdef PSRAM_WRITE_MASK_EN
      wmask_q <= wmask;
`endif
    end
  end

endmodule

// File: tb/tb_psram_phy_sequencer.sv
// Scoreboarded bench for psram_phy_sequencer: CA framing, write/read data phases, masking, back-to-back, reset.
module tb_psram_phy_sequencer;

  localparam int LATENCY   = 6;
  localparam int RECOVERY  = 2;
  localparam int RD_WINDOW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, we;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic [1:0]  wmask;
  logic        ack, busy, cs_n, ck_en, dq_oen, rwds_d0, rwds_d1, rwds_oen, rd_window;
  logic [7:0]  dq_d0, dq_d1;

  typedef struct {
    logic [47:0] ca;
    logic        we;
    logic [15:0] wdata;
    logic [1:0]  rwds;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  psram_phy_sequencer #(
    .LATENCY(LATENCY), .RECOVERY(RECOVERY), .RD_WINDOW(RD_WINDOW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wmask(wmask), .ack(ack), .busy(busy), .cs_n(cs_n), .ck_en(ck_en),
    .dq_d0(dq_d0), .dq_d1(dq_d1), .dq_oen(dq_oen), .rwds_d0(rwds_d0),
    .rwds_d1(rwds_d1), .rwds_oen(rwds_oen), .rd_window(rd_window)
  );

  function automatic logic [47:0] model_ca(input logic w, input logic [21:0] a);
    return {~w, 1'b0, 1'b1, 10'd0, a[21:3], 13'd0, a[2:0]};
  endfunction

  function automatic logic [1:0] model_rwds(input logic [1:0] m);
`ifdef PSRAM_WRITE_MASK_EN
    return {~m[1], ~m[0]};
`else
    return 2'b00 & m;
`endif
  endfunction

  task automatic push_and_drive(input logic w, input logic [21:0] a, input logic [15:0] d,
                                input logic [1:0] m, input logic [47:0] ca, input logic [1:0] rw);
    exp_t e;
    e.ca = ca; e.we = w; e.wdata = d; e.rwds = rw;
    sb.push_back(e);
    req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
  endtask

  // Waits for ack, pops the expectation and follows the access to the first recovery cycle.
  task automatic run_access(input bit drop, output int waited, output int cs_hi);
    exp_t e;
    waited = 0;
    cs_hi  = 0;
    while (1) begin
      @(negedge clk);
      waited++;
      if (ack === 1'b1) break;
      if (cs_n === 1'b1) cs_hi++;
      if (waited >= 60) break;
    end
    total++;
    if (ack !== 1'b1) begin
      $display("FAIL ack_timeout ack=%b required 1 after %0d cycles", ack, waited);
      return;
    end else passed++;
    if (drop) req = 1'b0;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL unexpected_ack queue_size=0 required >0");
      return;
    end else passed++;
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if ({dq_d0, dq_d1, dq_oen, rwds_oen, cs_n, ck_en, busy} !== {e.ca[47-16*k -: 16], 5'b01011})
        $display("FAIL ca%0d dq=%h/%h oen=%b/%b cs_n=%b ck_en=%b busy=%b required %h/%h 0/1 0 1 1",
                 k, dq_d0, dq_d1, dq_oen, rwds_oen, cs_n, ck_en, busy,
                 e.ca[47-16*k -: 8], e.ca[39-16*k -: 8]);
      else passed++;
      if (k == 1) begin
        total++;
        if (ack !== 1'b0) $display("FAIL ack_pulse ack=%b required 0", ack);
        else passed++;
      end
    end
    for (int k = 0; k < LATENCY; k++) begin
      @(negedge clk);
      total++;
      if ({cs_n, dq_oen, rwds_oen, dq_d0, dq_d1, rd_window} !== {3'b011, 16'h0000, 1'b0})
        $display("FAIL lat%0d cs_n=%b oen=%b/%b dq=%h/%h rd_window=%b required 0 1/1 00/00 0",
                 k, cs_n, dq_oen, rwds_oen, dq_d0, dq_d1, rd_window);
      else passed++;
    end
    if (e.we) begin
      @(negedge clk);
      total++;
      if ({dq_d0, dq_d1, dq_oen, rwds_oen, rwds_d0, rwds_d1, rd_window, cs_n} !==
          {e.wdata, 2'b00, e.rwds, 2'b00})
        $display("FAIL wdata dq=%h/%h oen=%b/%b rwds=%b/%b rd_window=%b cs_n=%b required %h 0/0 %b 0 0",
                 dq_d0, dq_d1, dq_oen, rwds_oen, rwds_d0, rwds_d1, rd_window, cs_n, e.wdata, e.rwds);
      else passed++;
    end else begin
      for (int k = 0; k < RD_WINDOW; k++) begin
        @(negedge clk);
        total++;
        if ({rd_window, dq_oen, rwds_oen, cs_n} !== 4'b1110)
          $display("FAIL rdwin%0d rd_window=%b oen=%b/%b cs_n=%b required 1 1/1 0",
                   k, rd_window, dq_oen, rwds_oen, cs_n);
        else passed++;
      end
    end
    @(negedge clk);
    total++;
    if ({cs_n, ck_en, rd_window, busy, dq_oen} !== 5'b10011)
      $display("FAIL recov cs_n=%b ck_en=%b rd_window=%b busy=%b dq_oen=%b required 1 0 0 1 1",
               cs_n, ck_en, rd_window, busy, dq_oen);
    else passed++;
  endtask

  task automatic test_reset();
    int w, h;
    reset_n = 1'b0;
    req = 1'b1; we = 1'b0; addr = 22'h3FFFFF; wdata = 16'h0; wmask = 2'b11;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({ack, busy, cs_n, ck_en, dq_d0, dq_d1, dq_oen, rwds_d0, rwds_d1, rwds_oen, rd_window} !==
          {4'b0010, 16'h0000, 5'b10010})
        $display("FAIL reset_vals ack=%b busy=%b cs_n=%b ck_en=%b dq=%h/%h oen=%b rwds=%b%b/%b rdw=%b required 0 0 1 0 00/00 1 00/1 0",
                 ack, busy, cs_n, ck_en, dq_d0, dq_d1, dq_oen, rwds_d0, rwds_d1, rwds_oen, rd_window);
      else passed++;
    end
    push_and_drive(1'b0, 22'h3FFFFF, 16'h0, 2'b11, model_ca(1'b0, 22'h3FFFFF), 2'b00);
    reset_n = 1'b1;
    run_access(1'b1, w, h);
    total++;
    if (w != 1) $display("FAIL reset_release_ack cycles=%0d required 1", w);
    else passed++;
  endtask

  task automatic test_single_write();
    int w, h;
    push_and_drive(1'b1, 22'h12345, 16'hA55A, 2'b11, 48'h2000_2468_0005, 2'b00);
    run_access(1'b1, w, h);
  endtask

  task automatic test_read();
    int w, h;
    push_and_drive(1'b0, 22'h0, 16'hFFFF, 2'b00, 48'hA000_0000_0000, 2'b00);
    run_access(1'b1, w, h);
  endtask

  task automatic test_masked_write();
    int w, h;
    logic [1:0] rw;
`ifdef PSRAM_WRITE_MASK_EN
    rw = 2'b10;
`else
    rw = 2'b00;
`endif
    push_and_drive(1'b1, 22'h2ABCDE, 16'h1234, 2'b01, model_ca(1'b1, 22'h2ABCDE), rw);
    run_access(1'b1, w, h);
  endtask

  task automatic test_random();
    int w, h;
    logic        rw_we;
    logic [21:0] ra;
    logic [15:0] rd;
    logic [1:0]  rm;
    for (int i = 0; i < 4; i++) begin
      rw_we = 1'($urandom_range(0, 1));
      ra    = 22'($urandom);
      rd    = 16'($urandom);
      rm    = 2'($urandom);
      push_and_drive(rw_we, ra, rd, rm, model_ca(rw_we, ra), model_rwds(rm));
      run_access(1'b1, w, h);
      repeat (i) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int w, h;
    exp_t e2;
    logic [21:0] a2;
    a2 = 22'h155555;
    push_and_drive(1'b1, 22'h0ABCD, 16'hC3E1, 2'b11, model_ca(1'b1, 22'h0ABCD), 2'b00);
    e2.ca = model_ca(1'b0, a2); e2.we = 1'b0; e2.wdata = 16'h0; e2.rwds = 2'b00;
    sb.push_back(e2);
    run_access(1'b0, w, h);
    we = 1'b0; addr = a2;
    run_access(1'b1, w, h);
    total++;
    if (w != RECOVERY + 1) $display("FAIL b2b_ack_gap cycles=%0d required %0d", w, RECOVERY + 1);
    else passed++;
    total++;
    if (h + 1 < RECOVERY) $display("FAIL b2b_cs_high cycles=%0d required >=%0d", h + 1, RECOVERY);
    else passed++;
  endtask

  task automatic test_reset_mid_lat();
    int w;
    req = 1'b1; we = 1'b1; addr = 22'h00777; wdata = 16'hBEEF; wmask = 2'b11;
    w = 0;
    while (1) begin
      @(negedge clk);
      w++;
      if (ack === 1'b1 || w >= 60) break;
    end
    total++;
    if (ack !== 1'b1) $display("FAIL abort_ack ack=%b required 1", ack);
    else passed++;
    req = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++;
    if ({cs_n, busy, ck_en, ack, dq_oen} !== 5'b10001)
      $display("FAIL abort_reset cs_n=%b busy=%b ck_en=%b ack=%b dq_oen=%b required 1 0 0 0 1",
               cs_n, busy, ck_en, ack, dq_oen);
    else passed++;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      total++;
      if ({ack, cs_n, rwds_oen, busy} !== 4'b0110)
        $display("FAIL abort_quiet%0d ack=%b cs_n=%b rwds_oen=%b busy=%b required 0 1 1 0",
                 k, ack, cs_n, rwds_oen, busy);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    repeat (3) @(negedge clk);
    test_single_write();
    repeat (2) @(negedge clk);
    test_read();
    repeat (2) @(negedge clk);
    test_masked_write();
    repeat (2) @(negedge clk);
    test_random();
    repeat (2) @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_mid_lat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required completion", $time);
    $fatal(1);
  end

endmodule
